// File: rtl/wbm_charlie_scroll.sv
// Wishbone B4 pipelined master that scrolls a 5x7 shadow frame into the charlie7x5 display.
// Each scroll tick shifts in one column from a valid/ready stream, then writes all five rows.
module wbm_charlie_scroll #(
   parameter int CLK_HZ         = 12000000,
   parameter int SCROLL_HZ      = 10,
   parameter bit BLANK_ON_EMPTY = 1'b1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        enable_i,
   input  logic [4:0]  col_data_i,
   input  logic        col_valid_i,
   output logic        col_ready_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_adr_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_stall_i,
   input  logic        wbm_ack_i,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic        overrun_o
);
   localparam int TICK = CLK_HZ / SCROLL_HZ;
   localparam int CW   = $clog2(TICK);

   typedef enum logic [1:0] {IDLE, SHIFT, ISSUE, WAIT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [6:0]      rows_q [5];
   logic [4:0]      col_q, col_d;
   logic [2:0]      issue_idx_q, issue_idx_d;
   logic [2:0]      ack_cnt_q, ack_cnt_d;
   logic            pending_q, pending_d;
   logic            done_q, done_d;
   logic            ovr_q, ovr_d;
   logic            tick, consume, col_ready, active;
   logic [6:0]      row_sel;
   logic            unused_dat;

   assign unused_dat = ^wbm_dat_i;
   assign tick       = (tick_cnt_q == CW'(TICK - 1));
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      issue_idx_d = issue_idx_q;
      ack_cnt_d   = ack_cnt_q;
      done_d      = 1'b0;
      consume     = 1'b0;
      col_ready   = 1'b0;
      if (wbm_ack_i && (state_q == ISSUE || state_q == WAIT) && ack_cnt_q < 3'd5)
         ack_cnt_d = ack_cnt_q + 3'd1;
      case (state_q)
         IDLE: begin
            if (pending_q) begin
               consume = 1'b1;
               if (enable_i) begin
                  if (col_valid_i) begin
                     col_ready = 1'b1;
                     col_d     = col_data_i;
                     state_d   = SHIFT;
                  end else if (BLANK_ON_EMPTY) begin
                     col_d   = 5'b0;
                     state_d = SHIFT;
                  end
               end
            end
         end
         SHIFT: begin
            state_d     = ISSUE;
            issue_idx_d = 3'd0;
            ack_cnt_d   = 3'd0;
         end
         ISSUE: begin
            if (!wbm_stall_i) begin
               if (issue_idx_q == 3'd4) state_d = WAIT;
               else issue_idx_d = issue_idx_q + 3'd1;
            end
         end
         WAIT: begin
            // The final ack may arrive in this very cycle.
            if (ack_cnt_q == 3'd5 || (wbm_ack_i && ack_cnt_q == 3'd4)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      pending_d = tick | (pending_q & ~consume);
      ovr_d     = tick & pending_q & ~consume;
   end

   // Reset lands in ISSUE with cleared rows so the display is blanked first.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= ISSUE;
         tick_cnt_q  <= '0;
         col_q       <= '0;
         issue_idx_q <= '0;
         ack_cnt_q   <= '0;
         pending_q   <= 1'b0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
         for (int r = 0; r < 5; r++) rows_q[r] <= '0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         col_q       <= col_d;
         issue_idx_q <= issue_idx_d;
         ack_cnt_q   <= ack_cnt_d;
         pending_q   <= pending_d;
         done_q      <= done_d;
         ovr_q       <= ovr_d;
         if (state_q == SHIFT)
            for (int r = 0; r < 5; r++) rows_q[r] <= {col_q[r], rows_q[r][6:1]};
      end
   end

   always_comb begin
      row_sel = 7'd0;
      case (issue_idx_q)
         3'd0: row_sel = rows_q[0];
         3'd1: row_sel = rows_q[1];
         3'd2: row_sel = rows_q[2];
         3'd3: row_sel = rows_q[3];
         3'd4: row_sel = rows_q[4];
         default: row_sel = 7'd0;
      endcase
   end

   // Bus controls drop combinationally while reset is held.
   assign active       = ~wb_rst_i;
   assign wbm_cyc_o    = active & (state_q == ISSUE || state_q == WAIT);
   assign wbm_stb_o    = active & (state_q == ISSUE);
   assign wbm_we_o     = wbm_stb_o;
   assign wbm_sel_o    = wbm_stb_o ? 4'b0001 : 4'b0000;
   assign wbm_adr_o    = {1'b0, issue_idx_q};
   assign wbm_dat_o    = {25'b0, row_sel};
   assign busy_o       = active & (state_q != IDLE);
   assign col_ready_o  = col_ready;
   assign frame_done_o = done_q;
   assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_wbm_charlie_scroll.sv
// Directed bench for wbm_charlie_scroll: flush, scrolling data, stall, overrun, blanking, reset mid-frame.
// A second instance with BLANK_ON_EMPTY=0 runs alongside with no columns offered.
module tb_wbm_charlie_scroll;
   logic        clk, rst, rst2;
   logic        enable, enable2, col_valid;
   logic [4:0]  col_data;
   logic        col_ready, cyc, stb, we, busy, frame_done, overrun;
   logic [3:0]  adr, sel;
   logic [31:0] dat_o;
   logic        stall, ack, ack_q, man_ack, block_last;
   logic        col_ready2, cyc2, stb2, we2, busy2, frame_done2, overrun2, ack2_q;
   logic [3:0]  adr2, sel2;
   logic [31:0] dat2;

   int tests, fails;
   int beats, cyc_cnt, done_cnt, ovr_cnt, rdy_cnt, sel_bad;
   int cyc2_cnt, done2_cnt, rdy2_cnt;
   logic [3:0]  adr_log [8];
   logic [31:0] dat_log [8];

   wbm_charlie_scroll #(.CLK_HZ(160), .SCROLL_HZ(10), .BLANK_ON_EMPTY(1'b1)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(enable), .col_data_i(col_data),
      .col_valid_i(col_valid), .col_ready_o(col_ready), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
      .wbm_we_o(we), .wbm_adr_o(adr), .wbm_sel_o(sel), .wbm_dat_o(dat_o), .wbm_dat_i(32'h0),
      .wbm_stall_i(stall), .wbm_ack_i(ack), .busy_o(busy), .frame_done_o(frame_done),
      .overrun_o(overrun));

   wbm_charlie_scroll #(.CLK_HZ(160), .SCROLL_HZ(10), .BLANK_ON_EMPTY(1'b0)) dut2 (
      .wb_clk_i(clk), .wb_rst_i(rst2), .enable_i(enable2), .col_data_i(5'b11111),
      .col_valid_i(1'b0), .col_ready_o(col_ready2), .wbm_cyc_o(cyc2), .wbm_stb_o(stb2),
      .wbm_we_o(we2), .wbm_adr_o(adr2), .wbm_sel_o(sel2), .wbm_dat_o(dat2), .wbm_dat_i(32'h0),
      .wbm_stall_i(1'b0), .wbm_ack_i(ack2_q), .busy_o(busy2), .frame_done_o(frame_done2),
      .overrun_o(overrun2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave model: one-cycle ack per accepted beat, last-beat ack optionally withheld.
   always @(posedge clk) begin
      ack_q  <= !rst && cyc && stb && !stall && !(block_last && adr == 4'd4);
      ack2_q <= !rst2 && cyc2 && stb2;
   end
   assign ack = ack_q | man_ack;

   always @(negedge clk) begin
      if (cyc && stb && !stall) begin
         if (beats < 8) begin
            adr_log[beats] = adr;
            dat_log[beats] = dat_o;
         end
         if (sel != 4'b0001 || !we) sel_bad++;
         beats++;
      end
      if (cyc) cyc_cnt++;
      if (frame_done) done_cnt++;
      if (overrun) ovr_cnt++;
      if (col_ready) rdy_cnt++;
      if (cyc2) cyc2_cnt++;
      if (frame_done2) done2_cnt++;
      if (col_ready2) rdy2_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      beats   = 0;
      cyc_cnt = 0;
      sel_bad = 0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < bound) begin
         step();
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done_cnt > d0), 32'd1);
   endtask

   task automatic wait_beats(input string tag, input int target, input int bound);
      int n = 0;
      while (beats < target && n < bound) begin
         step();
         n++;
      end
      chk({tag, "_beats_seen"}, 32'(beats >= target), 32'd1);
   endtask

   task automatic check_frame(input string tag, input logic [6:0] r0, input logic [6:0] r1,
                              input logic [6:0] r2, input logic [6:0] r3, input logic [6:0] r4);
      logic [6:0] e [5];
      e[0] = r0; e[1] = r1; e[2] = r2; e[3] = r3; e[4] = r4;
      chk({tag, "_beats"}, 32'(beats), 32'd5);
      chk({tag, "_sel_we"}, 32'(sel_bad), 32'd0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("%s_adr%0d", tag, i), 32'(adr_log[i]), 32'(i));
         chk($sformatf("%s_dat%0d", tag, i), dat_log[i], {25'b0, e[i]});
      end
   endtask

   initial begin
      tests = 0; fails = 0;
      beats = 0; cyc_cnt = 0; done_cnt = 0; ovr_cnt = 0; rdy_cnt = 0; sel_bad = 0;
      cyc2_cnt = 0; done2_cnt = 0; rdy2_cnt = 0;
      rst = 1'b1; rst2 = 1'b1;
      enable = 1'b0; enable2 = 1'b1; col_valid = 1'b0; col_data = 5'b0;
      stall = 1'b0; man_ack = 1'b0; block_last = 1'b0;
      repeat (3) step();

      chk("rst_cyc", 32'(cyc), 32'd0);
      chk("rst_stb", 32'(stb), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      chk("rst_ready", 32'(col_ready), 32'd0);

      // Blank flush after reset release.
      clear_log();
      done_cnt = 0;
      rst = 1'b0; rst2 = 1'b0;
      wait_done("flush", 40);
      check_frame("flush", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
      chk("flush_cyc_cycles", 32'(cyc_cnt), 32'd6);
      chk("flush_done_pulses", 32'(done_cnt), 32'd1);
      chk("flush_idle", 32'(busy), 32'd0);

      // Column 10101 enters at bit 6.
      enable = 1'b1; col_valid = 1'b1; col_data = 5'b10101;
      clear_log();
      wait_done("col1", 60);
      check_frame("col1", 7'h40, 7'h00, 7'h40, 7'h00, 7'h40);
      chk("col1_ready", 32'(rdy_cnt), 32'd1);

      col_data = 5'b00001;
      clear_log();
      wait_done("col2", 60);
      check_frame("col2", 7'h60, 7'h00, 7'h20, 7'h00, 7'h20);
      chk("col2_ready", 32'(rdy_cnt), 32'd2);

      // Stall three cycles while beat 2 is presented.
      col_data = 5'b11111;
      clear_log();
      begin
         int n = 0;
         while (!(stb && adr == 4'd2) && n < 60) begin
            step();
            n++;
         end
         chk("stall_reach_adr2", 32'(stb && adr == 4'd2), 32'd1);
      end
      col_valid = 1'b0;
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("stall_adr_hold%0d", k), 32'(adr), 32'd2);
         chk($sformatf("stall_dat_hold%0d", k), dat_o, 32'h50);
      end
      stall = 1'b0;
      wait_done("stall", 30);
      check_frame("stall", 7'h70, 7'h40, 7'h50, 7'h40, 7'h50);

      // Withhold the last ack long enough for two ticks to land during WAIT.
      block_last = 1'b1;
      clear_log();
      wait_beats("ovr", 5, 60);
      repeat (30) step();
      chk("ovr_wait_busy", 32'(busy), 32'd1);
      chk("ovr_wait_cyc", 32'(cyc), 32'd1);
      block_last = 1'b0;
      man_ack = 1'b1;
      step();
      man_ack = 1'b0;
      wait_done("ovr", 10);
      check_frame("ovr", 7'h38, 7'h20, 7'h28, 7'h20, 7'h28);
      chk("ovr_pulses", 32'(ovr_cnt), 32'd1);
      clear_log();
      wait_done("follow", 20);
      check_frame("follow", 7'h1C, 7'h10, 7'h14, 7'h10, 7'h14);
      chk("follow_ovr_pulses", 32'(ovr_cnt), 32'd1);
      chk("follow_ready", 32'(rdy_cnt), 32'd3);

      // Reset during WAIT of a nonzero frame.
      col_valid = 1'b1; col_data = 5'b11111;
      block_last = 1'b1;
      clear_log();
      wait_beats("rstmid", 5, 60);
      step();
      step();
      chk("rstmid_in_wait", 32'(cyc && !stb), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid_cyc", 32'(cyc), 32'd0);
      chk("rstmid_stb", 32'(stb), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      block_last = 1'b0;
      col_valid = 1'b0;
      step();
      step();
      clear_log();
      rst = 1'b0;
      wait_done("reflush", 40);
      check_frame("reflush", 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
      chk("reflush_cyc_cycles", 32'(cyc_cnt), 32'd6);

      // No-blank instance: only the reset flush, never a column handshake.
      chk("noblank_frames", 32'(done2_cnt), 32'd1);
      chk("noblank_cyc_cycles", 32'(cyc2_cnt), 32'd6);
      chk("noblank_ready", 32'(rdy2_cnt), 32'd0);
      chk("noblank_busy", 32'(busy2), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
